// File: rtl/prga.sv
// RC4 keystream (PRGA) stage: decrypts a length-prefixed ciphertext using an
// S array that the upstream key-schedule stage has already prepared.
module prga (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       rdy,
  output logic [7:0] s_addr,
  input  logic [7:0] s_rddata,
  output logic [7:0] s_wrdata,
  output logic       s_wren,
  output logic [7:0] ct_addr,
  input  logic [7:0] ct_rddata,
  output logic [7:0] pt_addr,
  output logic [7:0] pt_wrdata,
  output logic       pt_wren,
  output logic [3:0] state_dbg
);

  // Handshake: en is taken only on a rising clk edge where rdy=1; rdy stays low
  // from the following cycle until the run (or a reset) returns the FSM to IDLE.
  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    LEN    = 4'd1,
    RD_SI  = 4'd2,
    RD_SJ  = 4'd3,
    WR_SI  = 4'd4,
    WR_SJ  = 4'd5,
    RD_PAD = 4'd6,
    XOR    = 4'd7,
    DONE   = 4'd8
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] i, i_nxt;
  logic [7:0] j, j_nxt;
  logic [7:0] k, k_nxt;
  logic [7:0] len, len_nxt;
  logic [7:0] si, si_nxt;
  logic [7:0] sj, sj_nxt;

  logic [7:0] j_sum;
  logic [7:0] pad_idx;
  logic [7:0] i_inc;

  assign j_sum     = j + s_rddata;
  assign pad_idx   = si + sj;
  assign i_inc     = i + 8'd1;
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      i     <= 8'd0;
      j     <= 8'd0;
      k     <= 8'd0;
      len   <= 8'd0;
      si    <= 8'd0;
      sj    <= 8'd0;
    end else begin
      state <= state_nxt;
      i     <= i_nxt;
      j     <= j_nxt;
      k     <= k_nxt;
      len   <= len_nxt;
      si    <= si_nxt;
      sj    <= sj_nxt;
    end
  end

  // Memory addresses are driven combinationally so that synchronous-read data
  // lands in the very next state.
  always_comb begin
    state_nxt = state;
    i_nxt     = i;
    j_nxt     = j;
    k_nxt     = k;
    len_nxt   = len;
    si_nxt    = si;
    sj_nxt    = sj;
    rdy       = 1'b0;
    s_addr    = 8'd0;
    s_wrdata  = 8'd0;
    s_wren    = 1'b0;
    ct_addr   = 8'd0;
    pt_addr   = 8'd0;
    pt_wrdata = 8'd0;
    pt_wren   = 1'b0;

    case (state)
      IDLE: begin
        rdy = 1'b1;
        if (en) begin
          ct_addr   = 8'd0;
          i_nxt     = 8'd0;
          j_nxt     = 8'd0;
          k_nxt     = 8'd0;
          state_nxt = LEN;
        end
      end
      LEN: begin
        len_nxt   = ct_rddata;
        pt_addr   = 8'd0;
        pt_wrdata = ct_rddata;
        pt_wren   = 1'b1;
        if (ct_rddata == 8'd0) begin
          state_nxt = DONE;
        end else begin
          k_nxt     = 8'd1;
          i_nxt     = 8'd1;
          s_addr    = 8'd1;
          state_nxt = RD_SI;
        end
      end
      RD_SI: begin
        si_nxt    = s_rddata;
        j_nxt     = j_sum;
        s_addr    = j_sum;
        state_nxt = RD_SJ;
      end
      RD_SJ: begin
        sj_nxt    = s_rddata;
        state_nxt = WR_SI;
      end
      WR_SI: begin
        s_addr    = i;
        s_wrdata  = sj;
        s_wren    = 1'b1;
        state_nxt = WR_SJ;
      end
      // When i equals j both writes hit one location with the same value.
      WR_SJ: begin
        s_addr    = j;
        s_wrdata  = si;
        s_wren    = 1'b1;
        state_nxt = RD_PAD;
      end
      RD_PAD: begin
        s_addr    = pad_idx;
        ct_addr   = k;
        state_nxt = XOR;
      end
      XOR: begin
        pt_addr   = k;
        pt_wrdata = s_rddata ^ ct_rddata;
        pt_wren   = 1'b1;
        if (k == len) begin
          state_nxt = DONE;
        end else begin
          k_nxt     = k + 8'd1;
          i_nxt     = i_inc;
          s_addr    = i_inc;
          state_nxt = RD_SI;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
